logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined successor to the two-operation AND/OR select block: WIDTH-bit operands, eight selectable

---
 rtl/logic_unit_pkg.sv | 20 ++
 rtl/logic_unit_pipe_if.sv | 41 ++++
 rtl/logic_op_core.sv | 30 +++
 rtl/logic_unit_pipe.sv | 121 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared op-code definitions for the pipelined logic unit.
//   OP_W   : op-code width in bits
//   op_t   : op-code type
//   OP_*   : op-code values AND..NOT_A
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND    = 3'd0;
  localparam op_t OP_OR     = 3'd1;
  localparam op_t OP_XOR    = 3'd2;
  localparam op_t OP_NAND   = 3'd3;
  localparam op_t OP_NOR    = 3'd4;
  localparam op_t OP_XNOR   = 3'd5;
  localparam op_t OP_PASS_A = 3'd6;
  localparam op_t OP_NOT_A  = 3'd7;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for logic_unit_pipe.
//   master : operand source / result consumer (drives in_*, acc_clr, out_ready)
//   slave  : the logic unit (drives in_ready, out_valid, out_data, flags)
// Flag signals out_zero/out_par exist only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  op_t              in_op;
  logic             in_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero;
  logic             out_par;
`endif

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    input  out_zero, out_par,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    output out_zero, out_par,
`endif
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/logic_op_core.sv
// logic_op_core: combinational bitwise op unit, {a, b, op} -> result.
//   a_i, b_i : WIDTH-bit operands
//   op_i     : op code (logic_unit_pkg::OP_*)
//   res_o    : WIDTH-bit result
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (op_i)
      OP_AND:    res_o = a_i & b_i;
      OP_OR:     res_o = a_i | b_i;
      OP_XOR:    res_o = a_i ^ b_i;
      OP_NAND:   res_o = ~(a_i & b_i);
      OP_NOR:    res_o = ~(a_i | b_i);
      OP_XNOR:   res_o = ~(a_i ^ b_i);
      OP_PASS_A: res_o = a_i;
      OP_NOT_A:  res_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with accumulator mode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : logic_unit_pipe_if.slave (operand in, result out, acc_clr)
// Stage S1 registers the operand beat, stage S2 registers the result.
// Optional LOGIC_UNIT_FLAGS_EN adds registered out_zero/out_par flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  op_t              s1_op_q;
  logic             s1_acc_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             in_fire, s2_take, out_fire;
  logic [WIDTH-1:0] op_a, result;

  // S1 can advance into S2 when S2 is empty or draining this cycle.
  assign s2_take  = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign out_fire = s2_valid_q && bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !s1_valid_q || s2_take;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;

  always_comb begin
    op_a = s1_a_q;
    if (s1_acc_q) begin
      // A clear in the transfer cycle wins over the stale accumulator value.
      op_a = bus.acc_clr ? ACC_INIT : acc_q;
    end
  end

  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i  (op_a),
    .b_i  (s1_b_q),
    .op_i (s1_op_q),
    .res_o(result)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s2_take) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    if (s2_take) begin
      s2_valid_d = 1'b1;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = ACC_INIT;
    end else if (s2_take) begin
      acc_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_AND;
      s1_acc_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      acc_q      <= ACC_INIT;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
      if (in_fire) begin
        s1_a_q   <= bus.in_a;
        s1_b_q   <= bus.in_b;
        s1_op_q  <= bus.in_op;
        s1_acc_q <= bus.in_acc;
      end
      if (s2_take) begin
        s2_data_q <= result;
      end
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_q, par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (s2_take) begin
      zero_q <= (result == '0);
      par_q  <= ^result;
    end
  end

  assign bus.out_zero = zero_q;
  assign bus.out_par  = par_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe (WIDTH=8, ACC_INIT=0).
// Expected results are queued when a beat is accepted and compared when the beat leaves.
// Flag checks are active when LOGIC_UNIT_FLAGS_EN is defined.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       par;
    int         cyc;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic_unit_pipe_if #(.WIDTH(8)) bus ();

  logic_unit_pipe #(
    .WIDTH   (8),
    .ACC_INIT(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit lat);
    exp_t e;
    e.data = d;
    e.zero = (d == 8'h00);
    e.par  = ^d;
    e.cyc  = cyc;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Present one beat, hold it until accepted, then deassert in_valid after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input op_t op, input logic acc,
                      input logic [7:0] exp, input bit lat);
    int n;
    bit ok;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_acc   = acc;
    bus.in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push(exp, lat);
        ok = 1'b1;
      end
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every consumed result beat.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", {24'h0, bus.out_data}, {24'h0, mon_e.data});
        if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 2);
`ifdef LOGIC_UNIT_FLAGS_EN
        chk("out_zero", {31'h0, bus.out_zero}, {31'h0, mon_e.zero});
        chk("out_par", {31'h0, bus.out_par}, {31'h0, mon_e.par});
`endif
      end
    end
  end

  logic [7:0] op_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
  logic [7:0] acc_exp[4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
  logic [7:0] bp_b   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int         k;
    logic [7:0] held;
    bit         have_held;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = OP_AND;
    bus.in_acc    = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 0);
    chk("rst_out_data", {24'h0, bus.out_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 1);

    // All eight ops, back-to-back.
    for (int i = 0; i < 8; i++) send(8'hF0, 8'h3C, op_t'(i), 1'b0, op_exp[i], 1'b1);
    drain();

    // Accumulate chain after a clear.
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hEE, 8'h01 << i, OP_OR, 1'b1, acc_exp[i], 1'b1);
    drain();

    // Backpressure: stall the consumer for 5 cycles while streaming ~b.
    bus.out_ready = 1'b0;
    k             = 0;
    have_held     = 1'b0;
    held          = '0;
    bus.in_a      = 8'hFF;
    bus.in_b      = bp_b[0];
    bus.in_op     = OP_XOR;
    bus.in_acc    = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (have_held) chk("bp_hold", {24'h0, bus.out_data}, {24'h0, held});
        else begin
          held      = bus.out_data;
          have_held = 1'b1;
        end
      end
      if (bus.in_ready) begin
        push(~bp_b[k], 1'b0);
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 4) bus.in_b = bp_b[k];
    end
    chk("bp_accepts", k, 2);
    chk("bp_in_ready", {31'h0, bus.in_ready}, 0);
    chk("bp_held_first", {24'h0, held}, {24'h0, ~bp_b[0]});
    bus.out_ready = 1'b1;
    while (k < 4) begin
      send(8'hFF, bp_b[k], OP_XOR, 1'b0, ~bp_b[k], 1'b0);
      k++;
    end
    drain();

    // Clear coinciding with an accumulate transfer: A becomes ACC_INIT, acc ends at ACC_INIT.
    send(8'hAA, 8'h00, OP_OR, 1'b0, 8'hAA, 1'b1);
    drain();
    send(8'h00, 8'h55, OP_XOR, 1'b1, 8'h55, 1'b1);
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    drain();
    send(8'h00, 8'h00, OP_OR, 1'b1, 8'h00, 1'b1);
    drain();

    // Flag-oriented beats (flags compared only in the flags build).
    send(8'h0F, 8'h0F, OP_XOR, 1'b0, 8'h00, 1'b1);
    send(8'h07, 8'hA5, OP_PASS_A, 1'b0, 8'h07, 1'b1);
    drain();

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(8'h01, 8'h00, OP_OR, 1'b0, 8'h01, 1'b0);
    send(8'h02, 8'h00, OP_OR, 1'b0, 8'h02, 1'b0);
    chk("full_out_valid", {31'h0, bus.out_valid}, 1);
    chk("full_in_ready", {31'h0, bus.in_ready}, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'h0, bus.out_valid}, 0);
    chk("async_out_data", {24'h0, bus.out_data}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    chk("post_rst_in_ready", {31'h0, bus.in_ready}, 1);
    repeat (5) @(posedge clk);
    #1;
    send(8'h00, 8'h00, OP_OR, 1'b1, 8'h00, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
